rob_queue: RTL and testbench
============================

# rob_queue

Parametrised reorder buffer for the out-of-order RV32I core. It sits between decode/issue and the register file / LSB. It allocates one in-order tag per cycle and accepts results from `WB_PORTS` independent writeback channels. It retires at most one entry per cycle, in program order. Relative to the fixed-size ROB it adds:
- generic depth and port count;
- a store-commit handshake with the LSB;
- branch-mispredict flush with redirect PC;
- optional operand query ports.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AW`, `$clog2(DEPTH)`, tag width
- `XLEN`, 32, data/PC width
- `RD_W`, 5, architectural register index width
- `WB_PORTS`, 4, number of writeback channels

Ports:
- `clk_in` in 1 — single system clock, all state on rising edge
- `rst_in` in 1 — reset, asynchronous, active-low
- `rdy_in` in 1 — global enable; all state frozen while low
- `alloc_valid` in 1 — issue request
- `alloc_ready` out 1 — `count != DEPTH && !flush`
- `alloc_kind` in 2 — 0 reg-write, 1 store, 2 branch, 3 halt
- `alloc_rd` in RD_W — destination register
- `alloc_pc` in XLEN — instruction address
- `alloc_pred_taken` in 1 — predictor decision (branch only)
- `alloc_done` in 1 — result already known at issue (LUI/JAL)
- `alloc_value` in XLEN — that result
- `alloc_tag` out AW — tag given to the current request; equals tail (combinational)
- `wb_valid` in WB_PORTS — writeback strobes
- `wb_tag` in WB_PORTS*AW — tags, port i at bits [i*AW +: AW]
- `wb_value` in WB_PORTS*XLEN — results
- `wb_taken` in WB_PORTS — branch outcome
- `wb_target` in WB_PORTS*XLEN — branch target
- `commit_valid` out 1 — one-cycle retire pulse
- `commit_tag` out AW — retired tag
- `commit_rd` out RD_W — retired destination
- `commit_value` out XLEN — retired value
- `commit_reg_we` out 1 — set only for kind 0
- `store_go` out 1 — head store may write memory; level
- `store_tag` out AW — tag of that store
- `store_ack` in 1 — LSB finished the store
- `flush` out 1 — one-cycle mispredict pulse
- `flush_pc` out XLEN — redirect address
- `halt` out 1 — sticky; set when a halt entry retires
- `count` out AW+1 — occupied entries

## Operation
- Per-entry state: FREE, ISSUED, DONE. Pointers `head`, `tail` wrap modulo DEPTH. `count` is a separate register.
- **Allocate:** fires when `alloc_valid && alloc_ready && rdy_in`. The entry at tail becomes ISSUED, or DONE if `alloc_done`. Tail and count advance. Requests with `alloc_ready` low are ignored.
- **Writeback:** port i updates an entry only if that entry is ISSUED. The entry becomes DONE and stores value, taken, and target. Writebacks to FREE or DONE entries are ignored. If several ports hit the same tag, the highest index wins.
- **Retire FSM:** states RUN and ST_WAIT.
  - RUN, head DONE, kind ≠ store: retire. Pulse `commit_*`, free the head, advance head, decrement count.
  - RUN, head DONE, kind = store: set `store_go`, `store_tag = head`, go to ST_WAIT.
  - ST_WAIT: on `store_ack`, retire the store and return to RUN. `store_go` drops in the same edge.
- **Branch retire:** let `actual = wb_taken`.
  - `actual != alloc_pred_taken`: pulse `flush`. `flush_pc` = target if taken, else `pc+4`. In the same edge, all entries go FREE, `head = tail = 0`, `count = 0`, FSM goes to RUN.
  - `actual` matches prediction: plain retire, no flush.
  - `commit_value` for a branch is the target.
- **Halt retire:** sets `halt`; no further retires or allocations until reset.
- **Same cycle allocate + retire:** count unchanged.
- **Same cycle writeback to the head tag:** no same-cycle retire; retires on the following edge at the earliest.

## Timing
- Reset values: `head`, `tail`, `count` = 0; all entries FREE; FSM = RUN. `commit_valid`, `flush`, `store_go`, `halt` = 0. All data outputs = 0.
- Latency:
  - allocate→DONE-retire: ≥1 cycle;
  - writeback→retire: 1 cycle;
  - `store_ack`→`commit_valid`: 1 cycle.
- `commit_valid` and `flush` are registered one-cycle pulses, forced 0 while `rdy_in` is low. Other outputs hold while `rdy_in` is low.
- Full (`count == DEPTH`): `alloc_ready` = 0 even if a retire happens in the same cycle.
- Empty: no retire activity.
- An asynchronous reset mid-ST_WAIT abandons the store; the LSB is reset by the same `rst_in`.

## Configuration
- `ROB_QUERY_EN` defined: adds two operand-lookup ports.
  - `qry_tag` in 2*AW
  - `qry_ready` out 2
  - `qry_value` out 2*XLEN
  - Combinational. `qry_ready` = entry DONE, or any `wb_valid` this cycle carries that tag. In the forwarding case `qry_value` is the forwarded value, using the same highest-port priority.
- Not defined: ports absent; operands come only from the CDB.

## Test plan
- Reset, then allocate kind 0 with `alloc_done=1`, rd=5, value 0x1234 → next cycle `commit_valid=1`, `commit_rd=5`, `commit_value=0x1234`, `commit_reg_we=1`.
- Fill 16 entries with no writebacks → `count=16`, `alloc_ready=0`, further requests ignored. Then writeback tag 0 → retire; `alloc_ready` returns 1 one cycle later; tail wraps to 0.
- Writeback ports 0 and 3 to the same tag with values 0xA and 0xB in one cycle → retired value 0xB.
- Head store DONE → `store_go=1`; hold `store_ack=0` for 5 cycles with no retire; assert `store_ack` → `commit_valid` next cycle.
- Branch at pc 0x100, `pred_taken=0`, writeback taken=1, target 0x200 → `flush=1`, `flush_pc=0x200`, `count=0`, younger entries discarded, `alloc_ready=0` during the flush cycle.
- With `ROB_QUERY_EN`: query tag 3 while wb port 1 writes tag 3 value 0x55 → `qry_ready=1`, `qry_value=0x55` in the same cycle.

Source files
------------

// File: rtl/rob_queue_if.sv
// Bus bundle for rob_queue: allocate, writeback, commit, store handshake, flush and status.
// Operand query signals exist only when ROB_QUERY_EN is defined.
interface rob_queue_if #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int XLEN     = 32,
  parameter int RD_W     = 5,
  parameter int WB_PORTS = 4
);

  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [1:0]               alloc_kind;
  logic [RD_W-1:0]          alloc_rd;
  logic [XLEN-1:0]          alloc_pc;
  logic                     alloc_pred_taken;
  logic                     alloc_done;
  logic [XLEN-1:0]          alloc_value;
  logic [AW-1:0]            alloc_tag;

  logic [WB_PORTS-1:0]      wb_valid;
  logic [WB_PORTS*AW-1:0]   wb_tag;
  logic [WB_PORTS*XLEN-1:0] wb_value;
  logic [WB_PORTS-1:0]      wb_taken;
  logic [WB_PORTS*XLEN-1:0] wb_target;

  logic                     commit_valid;
  logic [AW-1:0]            commit_tag;
  logic [RD_W-1:0]          commit_rd;
  logic [XLEN-1:0]          commit_value;
  logic                     commit_reg_we;

  logic                     store_go;
  logic [AW-1:0]            store_tag;
  logic                     store_ack;

  logic                     flush;
  logic [XLEN-1:0]          flush_pc;
  logic                     halt;
  logic [AW:0]              count;

`ifdef ROB_QUERY_EN
  logic [2*AW-1:0]          qry_tag;
  logic [1:0]               qry_ready;
  logic [2*XLEN-1:0]        qry_value;
`endif

  modport master (
`ifdef ROB_QUERY_EN
    output qry_tag,
    input  qry_ready, qry_value,
`endif
    output alloc_valid, alloc_kind, alloc_rd, alloc_pc, alloc_pred_taken,
    output alloc_done, alloc_value,
    input  alloc_ready, alloc_tag,
    output wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    input  commit_valid, commit_tag, commit_rd, commit_value, commit_reg_we,
    input  store_go, store_tag,
    output store_ack,
    input  flush, flush_pc, halt, count
  );

  modport slave (
`ifdef ROB_QUERY_EN
    input  qry_tag,
    output qry_ready, qry_value,
`endif
    input  alloc_valid, alloc_kind, alloc_rd, alloc_pc, alloc_pred_taken,
    input  alloc_done, alloc_value,
    output alloc_ready, alloc_tag,
    input  wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    output commit_valid, commit_tag, commit_rd, commit_value, commit_reg_we,
    output store_go, store_tag,
    input  store_ack,
    output flush, flush_pc, halt, count
  );

endinterface

// File: rtl/rob_queue.sv
// Parametrised reorder buffer: in-order allocate, multi-port writeback, in-order retire with
// store-commit handshake, mispredict flush and sticky halt. ROB_QUERY_EN adds operand query ports.
module rob_queue #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int XLEN     = 32,
  parameter int RD_W     = 5,
  parameter int WB_PORTS = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  rob_queue_if.slave bus
);

  typedef enum logic [1:0] {E_FREE, E_ISSUED, E_DONE} entry_t;
  typedef enum logic {RUN, ST_WAIT} fsm_t;

  localparam logic [1:0] K_REG    = 2'd0;
  localparam logic [1:0] K_STORE  = 2'd1;
  localparam logic [1:0] K_BRANCH = 2'd2;
  localparam logic [1:0] K_HALT   = 2'd3;

  entry_t          st       [DEPTH];
  logic [1:0]      kind_q   [DEPTH];
  logic [RD_W-1:0] rd_q     [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [XLEN-1:0] value_q  [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic            pred_q   [DEPTH];
  logic            taken_q  [DEPTH];

  logic            wb_hit [DEPTH];
  logic [XLEN-1:0] wb_val [DEPTH];
  logic            wb_tkn [DEPTH];
  logic [XLEN-1:0] wb_tgt [DEPTH];

  logic [AW-1:0]   head, tail;
  logic [AW:0]     count;
  fsm_t            state, state_nxt;

  logic            halt_q, flush_q, commit_valid_q, store_go_q, commit_reg_we_q;
  logic [AW-1:0]   commit_tag_q, store_tag_q;
  logic [RD_W-1:0] commit_rd_q;
  logic [XLEN-1:0] commit_value_q, flush_pc_q;

  logic            alloc_ready, alloc_fire;
  logic            retire, mispredict, store_start;
  logic [1:0]      head_kind;

  assign head_kind   = kind_q[head];
  assign alloc_ready = (count != (AW+1)'(DEPTH)) && !flush_q && !halt_q;
  assign alloc_fire  = bus.alloc_valid && alloc_ready && rdy_in;

  // Per-entry writeback decode; scanning ports upward lets the highest port win a shared tag.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wb_hit[e] = 1'b0;
      wb_val[e] = '0;
      wb_tkn[e] = 1'b0;
      wb_tgt[e] = '0;
      for (int i = 0; i < WB_PORTS; i++) begin
        if (bus.wb_valid[i] && (bus.wb_tag[i*AW +: AW] == AW'(e))) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = bus.wb_value[i*XLEN +: XLEN];
          wb_tkn[e] = bus.wb_taken[i];
          wb_tgt[e] = bus.wb_target[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= RUN;
    else         state <= state_nxt;
  end

  // Retire decisions look only at registered entry state, so a same-cycle writeback never retires.
  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    mispredict  = 1'b0;
    store_start = 1'b0;
    if (rdy_in && !halt_q) begin
      case (state)
        RUN: begin
          if (st[head] == E_DONE) begin
            if (head_kind == K_STORE) begin
              store_start = 1'b1;
              state_nxt   = ST_WAIT;
            end else begin
              retire     = 1'b1;
              mispredict = (head_kind == K_BRANCH) && (taken_q[head] != pred_q[head]);
            end
          end
        end
        ST_WAIT: begin
          if (bus.store_ack) begin
            retire    = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int e = 0; e < DEPTH; e++) st[e] <= E_FREE;
    end else if (rdy_in) begin
      if (mispredict) begin
        for (int e = 0; e < DEPTH; e++) st[e] <= E_FREE;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (st[e] == E_ISSUED && wb_hit[e]) st[e] <= E_DONE;
        end
        if (alloc_fire) st[tail] <= bus.alloc_done ? E_DONE : E_ISSUED;
        if (retire)     st[head] <= E_FREE;
      end
    end
  end

  // Payload storage needs no reset: it is only read once the entry's state says it is valid.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (st[e] == E_ISSUED && wb_hit[e]) begin
          value_q[e]  <= wb_val[e];
          taken_q[e]  <= wb_tkn[e];
          target_q[e] <= wb_tgt[e];
        end
      end
      if (alloc_fire) begin
        kind_q[tail]   <= bus.alloc_kind;
        rd_q[tail]     <= bus.alloc_rd;
        pc_q[tail]     <= bus.alloc_pc;
        pred_q[tail]   <= bus.alloc_pred_taken;
        value_q[tail]  <= bus.alloc_value;
        taken_q[tail]  <= 1'b0;
        target_q[tail] <= '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      halt_q          <= 1'b0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      commit_valid_q  <= 1'b0;
      commit_tag_q    <= '0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_reg_we_q <= 1'b0;
      store_go_q      <= 1'b0;
      store_tag_q     <= '0;
    end else if (!rdy_in) begin
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      commit_valid_q <= retire;
      flush_q        <= mispredict;
      if (retire) begin
        commit_tag_q    <= head;
        commit_rd_q     <= rd_q[head];
        commit_value_q  <= (head_kind == K_BRANCH) ? target_q[head] : value_q[head];
        commit_reg_we_q <= (head_kind == K_REG);
        if (head_kind == K_HALT) halt_q <= 1'b1;
      end
      if (store_start) begin
        store_go_q  <= 1'b1;
        store_tag_q <= head;
      end else if (retire && state == ST_WAIT) begin
        store_go_q  <= 1'b0;
      end
      if (mispredict) begin
        flush_pc_q <= taken_q[head] ? target_q[head] : pc_q[head] + XLEN'(4);
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (retire)     head <= head + AW'(1);
        if (alloc_fire) tail <= tail + AW'(1);
        if (alloc_fire && !retire)      count <= count + (AW+1)'(1);
        else if (!alloc_fire && retire) count <= count - (AW+1)'(1);
      end
    end
  end

  assign bus.alloc_ready   = alloc_ready;
  assign bus.alloc_tag     = tail;
  assign bus.commit_valid  = commit_valid_q && rdy_in;
  assign bus.commit_tag    = commit_tag_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_value  = commit_value_q;
  assign bus.commit_reg_we = commit_reg_we_q;
  assign bus.store_go      = store_go_q;
  assign bus.store_tag     = store_tag_q;
  assign bus.flush         = flush_q && rdy_in;
  assign bus.flush_pc      = flush_pc_q;
  assign bus.halt          = halt_q;
  assign bus.count         = count;

`ifdef ROB_QUERY_EN
  // A completed entry answers from storage; otherwise an in-flight writeback is forwarded.
  always_comb begin
    bus.qry_ready = '0;
    bus.qry_value = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < WB_PORTS; i++) begin
        if (bus.wb_valid[i] && (bus.wb_tag[i*AW +: AW] == bus.qry_tag[k*AW +: AW])) begin
          bus.qry_ready[k]              = 1'b1;
          bus.qry_value[k*XLEN +: XLEN] = bus.wb_value[i*XLEN +: XLEN];
        end
      end
      if (st[bus.qry_tag[k*AW +: AW]] == E_DONE) begin
        bus.qry_ready[k]              = 1'b1;
        bus.qry_value[k*XLEN +: XLEN] = value_q[bus.qry_tag[k*AW +: AW]];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue; commits are matched in order against a scoreboard queue.
// Define ROB_QUERY_EN for both DUT and bench to cover the query ports.
`timescale 1ns/1ps
module tb_rob_queue;

  localparam int DEPTH = 16, AW = 4, XLEN = 32, RD_W = 5, WB_PORTS = 4;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  always #5 clk = ~clk;

  rob_queue_if #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN), .RD_W(RD_W), .WB_PORTS(WB_PORTS)) bus ();

  rob_queue #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN), .RD_W(RD_W), .WB_PORTS(WB_PORTS)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus)
  );

  typedef struct {
    logic [AW-1:0]   tag;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
    logic            we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;

  always @(negedge clk) begin
    if (rst_n && bus.commit_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL commit_unexpected: got tag %0d value %h, expected no commit",
                 bus.commit_tag, bus.commit_value);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.commit_tag, bus.commit_rd, bus.commit_value, bus.commit_reg_we} !==
            {mon_e.tag, mon_e.rd, mon_e.value, mon_e.we}) begin
          miscompares++;
          $display("[TB] FAIL commit_data: got tag %0d rd %0d value %h we %b, want tag %0d rd %0d value %h we %b",
                   bus.commit_tag, bus.commit_rd, bus.commit_value, bus.commit_reg_we,
                   mon_e.tag, mon_e.rd, mon_e.value, mon_e.we);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid      = 1'b0;
    bus.alloc_kind       = 2'd0;
    bus.alloc_rd         = '0;
    bus.alloc_pc         = '0;
    bus.alloc_pred_taken = 1'b0;
    bus.alloc_done       = 1'b0;
    bus.alloc_value      = '0;
    bus.wb_valid         = '0;
    bus.wb_tag           = '0;
    bus.wb_value         = '0;
    bus.wb_taken         = '0;
    bus.wb_target        = '0;
    bus.store_ack        = 1'b0;
`ifdef ROB_QUERY_EN
    bus.qry_tag          = '0;
`endif
  endtask

  task automatic alloc_set(input logic [1:0] kind, input int rd, input logic [XLEN-1:0] pc,
                           input logic pred, input logic done, input logic [XLEN-1:0] value);
    bus.alloc_valid      = 1'b1;
    bus.alloc_kind       = kind;
    bus.alloc_rd         = RD_W'(rd);
    bus.alloc_pc         = pc;
    bus.alloc_pred_taken = pred;
    bus.alloc_done       = done;
    bus.alloc_value      = value;
  endtask

  task automatic wb_set(input int p, input int tag, input logic [XLEN-1:0] value,
                        input logic taken, input logic [XLEN-1:0] target);
    bus.wb_valid[p]                = 1'b1;
    bus.wb_tag[p*AW +: AW]         = AW'(tag);
    bus.wb_value[p*XLEN +: XLEN]   = value;
    bus.wb_taken[p]                = taken;
    bus.wb_target[p*XLEN +: XLEN]  = target;
  endtask

  task automatic push_exp(input int tag, input int rd, input logic [XLEN-1:0] value, input logic we);
    exp_t e;
    e.tag = AW'(tag); e.rd = RD_W'(rd); e.value = value; e.we = we;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    sb.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if (bus.count !== 5'd0 || bus.alloc_tag !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ptrs: got count %0d tag %0d, want 0 0", bus.count, bus.alloc_tag);
    end
    vectors++;
    if ({bus.commit_valid, bus.flush, bus.store_go, bus.halt} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got cv/fl/sg/h %b%b%b%b, want 0000",
               bus.commit_valid, bus.flush, bus.store_go, bus.halt);
    end
    vectors++;
    if (bus.commit_value !== 32'h0 || bus.flush_pc !== 32'h0 || bus.alloc_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got cval %h fpc %h ready %b, want 0 0 1",
               bus.commit_value, bus.flush_pc, bus.alloc_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alloc_done();
    alloc_set(2'd0, 5, 32'h0, 1'b0, 1'b1, 32'h1234);
    vectors++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL alloc_first: got ready %b tag %0d, want 1 0", bus.alloc_ready, bus.alloc_tag);
    end
    push_exp(0, 5, 32'h1234, 1'b1);
    tick();
    idle();
    vectors++;
    if (bus.commit_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alloc_early: got commit_valid %b on allocate edge, want 0", bus.commit_valid);
    end
    for (int n = 0; n < 8 && sb.size() != 0; n++) tick();
    vectors++;
    if (sb.size() != 0 || bus.count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL alloc_retire: got pending %0d count %0d, want 0 0", sb.size(), bus.count);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_set(2'd0, i, 32'h0, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (bus.alloc_tag !== AW'(i) || bus.alloc_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL fill_tag: got tag %0d ready %b, want %0d 1", bus.alloc_tag, bus.alloc_ready, i);
      end
      tick();
    end
    tick(); tick();
    vectors++;
    if (bus.count !== 5'd16 || bus.alloc_ready !== 1'b0 || bus.alloc_tag !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL full_state: got count %0d ready %b tag %0d, want 16 0 0",
               bus.count, bus.alloc_ready, bus.alloc_tag);
    end
    idle();
    wb_set(0, 0, 32'h100, 1'b0, 32'h0);
    push_exp(0, 0, 32'h100, 1'b1);
    tick();
    idle();
    alloc_set(2'd0, 30, 32'h0, 1'b0, 1'b1, 32'hBAD);
    vectors++;
    if (bus.alloc_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_retire_ready: got ready %b while full and retiring, want 0", bus.alloc_ready);
    end
    tick();
    idle();
    vectors++;
    if (bus.count !== 5'd15 || bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL full_after_retire: got count %0d ready %b tag %0d, want 15 1 0",
               bus.count, bus.alloc_ready, bus.alloc_tag);
    end
    for (int t = 1; t < DEPTH; t += 4) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (t + p < DEPTH) begin
          wb_set(p, t + p, 32'h100 + 32'(t + p), 1'b0, 32'h0);
          push_exp(t + p, t + p, 32'h100 + 32'(t + p), 1'b1);
        end
      end
      tick();
      idle();
    end
    for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
    vectors++;
    if (sb.size() != 0 || bus.count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got pending %0d count %0d, want 0 0", sb.size(), bus.count);
    end
  endtask

  task automatic test_wb_priority();
    alloc_set(2'd0, 1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    alloc_set(2'd0, 2, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    wb_set(0, 1, 32'hA, 1'b0, 32'h0);
    wb_set(3, 1, 32'hB, 1'b0, 32'h0);
    tick();
    idle();
    wb_set(1, 1, 32'hC, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    vectors++;
    if (bus.count !== 5'd2) begin
      miscompares++;
      $display("[TB] FAIL prio_blocked: got count %0d, want 2", bus.count);
    end
    push_exp(0, 1, 32'h77, 1'b1);
    push_exp(1, 2, 32'hB, 1'b1);
    wb_set(2, 0, 32'h77, 1'b0, 32'h0);
    tick();
    idle();
    for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL prio_drain: got pending %0d, want 0", sb.size());
    end
  endtask

  task automatic test_store();
    alloc_set(2'd1, 0, 32'h0, 1'b0, 1'b1, 32'h44);
    push_exp(2, 0, 32'h44, 1'b0);
    tick();
    idle();
    vectors++;
    if (bus.store_go !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL store_go_early: got %b, want 0", bus.store_go);
    end
    tick();
    vectors++;
    if (bus.store_go !== 1'b1 || bus.store_tag !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL store_go: got go %b tag %0d, want 1 2", bus.store_go, bus.store_tag);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      vectors++;
      if (bus.commit_valid !== 1'b0 || bus.store_go !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL store_wait: got cv %b go %b, want 0 1", bus.commit_valid, bus.store_go);
      end
    end
    rdy = 1'b0;
    bus.store_ack = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.commit_valid !== 1'b0 || bus.store_go !== 1'b1 || bus.count !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL store_frozen: got cv %b go %b count %0d, want 0 1 1",
               bus.commit_valid, bus.store_go, bus.count);
    end
    rdy = 1'b1;
    tick();
    bus.store_ack = 1'b0;
    vectors++;
    if (bus.commit_valid !== 1'b1 || bus.store_go !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL store_commit: got cv %b go %b, want 1 0", bus.commit_valid, bus.store_go);
    end
    tick();
    vectors++;
    if (bus.commit_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL store_pulse: got cv %b pending %0d, want 0 0", bus.commit_valid, sb.size());
    end
    alloc_set(2'd1, 0, 32'h0, 1'b0, 1'b1, 32'h66);
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.store_go !== 1'b0 || bus.count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL store_reset: got go %b count %0d, want 0 0", bus.store_go, bus.count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    alloc_set(2'd2, 0, 32'h300, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    wb_set(0, 0, 32'h304, 1'b1, 32'h380);
    push_exp(0, 0, 32'h380, 1'b0);
    tick();
    idle();
    tick();
    vectors++;
    if (bus.flush !== 1'b0 || bus.commit_valid !== 1'b1 || bus.count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL br_correct: got flush %b cv %b count %0d, want 0 1 0",
               bus.flush, bus.commit_valid, bus.count);
    end
    alloc_set(2'd2, 0, 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    alloc_set(2'd0, 3, 32'h104, 1'b0, 1'b1, 32'h1);
    tick();
    alloc_set(2'd0, 4, 32'h108, 1'b0, 1'b1, 32'h2);
    tick();
    idle();
    wb_set(2, 1, 32'h104, 1'b1, 32'h200);
    push_exp(1, 0, 32'h200, 1'b0);
    tick();
    idle();
    tick();
    vectors++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL br_flush: got flush %b pc %h, want 1 00000200", bus.flush, bus.flush_pc);
    end
    vectors++;
    if (bus.count !== 5'd0 || bus.alloc_ready !== 1'b0 || bus.alloc_tag !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL br_flush_state: got count %0d ready %b tag %0d, want 0 0 0",
               bus.count, bus.alloc_ready, bus.alloc_tag);
    end
    alloc_set(2'd0, 9, 32'h0, 1'b0, 1'b1, 32'h9);
    tick();
    idle();
    vectors++;
    if (bus.flush !== 1'b0 || bus.count !== 5'd0 || bus.alloc_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL br_after_flush: got flush %b count %0d ready %b, want 0 0 1",
               bus.flush, bus.count, bus.alloc_ready);
    end
    repeat (4) tick();
    alloc_set(2'd2, 0, 32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    wb_set(3, 0, 32'h44, 1'b0, 32'h80);
    push_exp(0, 0, 32'h80, 1'b0);
    tick();
    idle();
    tick();
    vectors++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h44) begin
      miscompares++;
      $display("[TB] FAIL br_nottaken: got flush %b pc %h, want 1 00000044", bus.flush, bus.flush_pc);
    end
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL br_drain: got pending %0d, want 0", sb.size());
    end
  endtask

  task automatic test_halt();
    do_reset();
    alloc_set(2'd3, 0, 32'h500, 1'b0, 1'b1, 32'h0);
    push_exp(0, 0, 32'h0, 1'b0);
    tick();
    idle();
    tick();
    vectors++;
    if (bus.halt !== 1'b1 || bus.commit_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL halt_set: got halt %b cv %b, want 1 1", bus.halt, bus.commit_valid);
    end
    alloc_set(2'd0, 1, 32'h504, 1'b0, 1'b1, 32'h5);
    repeat (3) tick();
    idle();
    tick();
    vectors++;
    if (bus.count !== 5'd0 || bus.halt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL halt_stuck: got count %0d halt %b, want 0 1", bus.count, bus.halt);
    end
    do_reset();
    vectors++;
    if (bus.halt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: got %b, want 0", bus.halt);
    end
  endtask

`ifdef ROB_QUERY_EN
  task automatic test_query();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_set(2'd0, 10 + i, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    idle();
    bus.qry_tag = {4'd2, 4'd3};
    #1;
    vectors++;
    if (bus.qry_ready !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL qry_idle: got ready %b, want 00", bus.qry_ready);
    end
    wb_set(1, 3, 32'h55, 1'b0, 32'h0);
    #1;
    vectors++;
    if (bus.qry_ready !== 2'b01 || bus.qry_value[31:0] !== 32'h55) begin
      miscompares++;
      $display("[TB] FAIL qry_forward: got ready %b value %h, want 01 00000055",
               bus.qry_ready, bus.qry_value[31:0]);
    end
    tick();
    bus.wb_valid = '0;
    #1;
    vectors++;
    if (bus.qry_ready !== 2'b01 || bus.qry_value[31:0] !== 32'h55) begin
      miscompares++;
      $display("[TB] FAIL qry_stored: got ready %b value %h, want 01 00000055",
               bus.qry_ready, bus.qry_value[31:0]);
    end
    do_reset();
  endtask
`endif

  initial begin
    $display("[TB] rob_queue bench start");
    test_reset();
    test_alloc_done();
    test_full();
    test_wb_priority();
    test_store();
    test_branch();
    test_halt();
`ifdef ROB_QUERY_EN
    test_query();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
